// File: rtl/pcie_detect_ctrl.sv
// ============================================================================
// Module   : pcie_detect_ctrl
// Brief    : LTSSM Detect sequencer (Quiet / Active / single retry) with
//            receiver-detect handshake, watchdog and detected-lane hand-off.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pcie_detect_ctrl #(
    parameter int NUM_LANES         = 4,
    parameter int RXDET_TIMEOUT_CYC = 64
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 ltssm_en_i,
    input  logic [NUM_LANES-1:0] eidle_exit_i,
    input  logic                 timer_expired_i,
    output logic                 timer_en_o,
    output logic                 rxdet_req_o,
    input  logic                 rxdet_done_i,
    input  logic [NUM_LANES-1:0] rxdet_present_i,
    output logic [NUM_LANES-1:0] lanes_active_o,
    output logic                 detect_done_o,
    output logic [2:0]           state_o
);

    localparam int CNT_W = (RXDET_TIMEOUT_CYC > 1) ? $clog2(RXDET_TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(RXDET_TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_QUIET      = 3'd1,
        ST_ACTIVE1    = 3'd2,
        ST_RETRY_WAIT = 3'd3,
        ST_ACTIVE2    = 3'd4,
        ST_DONE       = 3'd5
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     wd_cnt_q;
    logic [NUM_LANES-1:0] retry_mask_q, retry_mask_d;
    logic [NUM_LANES-1:0] lanes_q;
    logic                 timer_en_q, rxdet_req_q, done_q;
    logic                 wd_timeout;

    // A done strobe in the timeout cycle is evaluated first, so it wins.
    assign wd_timeout = (wd_cnt_q == WD_LAST);

    always_comb begin
        state_d      = state_q;
        retry_mask_d = retry_mask_q;
        case (state_q)
            ST_IDLE:       state_d = ST_QUIET;
            ST_QUIET: begin
                if (timer_expired_i || (|eidle_exit_i))
                    state_d = ST_ACTIVE1;
            end
            ST_ACTIVE1: begin
                if (rxdet_done_i) begin
                    if (&rxdet_present_i) begin
                        state_d = ST_DONE;
                    end else if (rxdet_present_i == '0) begin
                        state_d = ST_QUIET;
                    end else begin
                        state_d      = ST_RETRY_WAIT;
                        retry_mask_d = rxdet_present_i;
                    end
                end else if (wd_timeout) begin
                    state_d = ST_QUIET;
                end
            end
            ST_RETRY_WAIT: begin
                if (timer_expired_i)
                    state_d = ST_ACTIVE2;
            end
            ST_ACTIVE2: begin
                if (rxdet_done_i && (rxdet_present_i == retry_mask_q)
                    && (rxdet_present_i != '0)) begin
                    state_d = ST_DONE;
                end else if (rxdet_done_i || wd_timeout) begin
                    state_d      = ST_QUIET;
                    retry_mask_d = '0;
                end
            end
            ST_DONE:       state_d = ST_DONE;
            default:       state_d = ST_IDLE;
        endcase
        if (!ltssm_en_i) begin
            state_d      = ST_IDLE;
            retry_mask_d = retry_mask_q;
        end
    end

    // Outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            wd_cnt_q     <= '0;
            retry_mask_q <= '0;
            lanes_q      <= '0;
            timer_en_q   <= 1'b0;
            rxdet_req_q  <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            retry_mask_q <= retry_mask_d;
            timer_en_q   <= (state_d == ST_QUIET) || (state_d == ST_RETRY_WAIT);
            rxdet_req_q  <= (state_d == ST_ACTIVE1) || (state_d == ST_ACTIVE2);
            done_q       <= (state_d == ST_DONE);
            if ((state_q == ST_ACTIVE1) || (state_q == ST_ACTIVE2))
                wd_cnt_q <= wd_cnt_q + 1'b1;
            else
                wd_cnt_q <= '0;
            if ((state_d == ST_DONE) && (state_q != ST_DONE))
                lanes_q <= rxdet_present_i;
            else if ((state_q == ST_DONE) && (state_d != ST_DONE))
                lanes_q <= '0;
        end
    end

    assign timer_en_o     = timer_en_q;
    assign rxdet_req_o    = rxdet_req_q;
    assign detect_done_o  = done_q;
    assign lanes_active_o = lanes_q;
    assign state_o        = state_q;

endmodule

`default_nettype wire

// File: tb/tb_pcie_detect_ctrl.sv
// ============================================================================
// Module   : tb_pcie_detect_ctrl
// Brief    : Directed self-checking bench for pcie_detect_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pcie_detect_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       ltssm_en_i;
    logic [3:0] eidle_exit_i;
    logic       timer_expired_i;
    logic       timer_en_o;
    logic       rxdet_req_o;
    logic       rxdet_done_i;
    logic [3:0] rxdet_present_i;
    logic [3:0] lanes_active_o;
    logic       detect_done_o;
    logic [2:0] state_o;

    int checks = 0;
    int errors = 0;

    pcie_detect_ctrl #(.NUM_LANES(4), .RXDET_TIMEOUT_CYC(64)) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .ltssm_en_i      (ltssm_en_i),
        .eidle_exit_i    (eidle_exit_i),
        .timer_expired_i (timer_expired_i),
        .timer_en_o      (timer_en_o),
        .rxdet_req_o     (rxdet_req_o),
        .rxdet_done_i    (rxdet_done_i),
        .rxdet_present_i (rxdet_present_i),
        .lanes_active_o  (lanes_active_o),
        .detect_done_o   (detect_done_o),
        .state_o         (state_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "bench timeout");
    end

    initial begin
        rst_ni = 1'b0; ltssm_en_i = 1'b0; eidle_exit_i = '0;
        timer_expired_i = 1'b0; rxdet_done_i = 1'b0; rxdet_present_i = '0;
        #23;
        chk("rst_state",    state_o, 0);
        chk("rst_timer_en", timer_en_o, 0);
        chk("rst_req",      rxdet_req_o, 0);
        chk("rst_done",     detect_done_o, 0);
        chk("rst_lanes",    lanes_active_o, 0);
        ltssm_en_i = 1'b1;
        @(negedge clk_i); rst_ni = 1'b1;
        step();
        chk("t1_quiet_state", state_o, 1);
        chk("t1_quiet_timer", timer_en_o, 1);
        timer_expired_i = 1'b1; step(); timer_expired_i = 1'b0;
        chk("t1_act1_state", state_o, 2);
        chk("t1_act1_req",   rxdet_req_o, 1);
        chk("t1_act1_timer", timer_en_o, 0);

        // All lanes present on first attempt
        rxdet_done_i = 1'b1; rxdet_present_i = 4'hF; step(); rxdet_done_i = 1'b0;
        chk("t2_done_state", state_o, 5);
        chk("t2_done_flag",  detect_done_o, 1);
        chk("t2_done_lanes", lanes_active_o, 4'hF);
        ltssm_en_i = 1'b0; step();
        chk("t2_idle_state", state_o, 0);
        chk("t2_idle_lanes", lanes_active_o, 0);
        chk("t2_idle_done",  detect_done_o, 0);

        // Partial detection, retry confirms
        ltssm_en_i = 1'b1; step();
        timer_expired_i = 1'b1; step(); timer_expired_i = 1'b0;
        rxdet_done_i = 1'b1; rxdet_present_i = 4'b0011; step(); rxdet_done_i = 1'b0;
        chk("t3_rw_state", state_o, 3);
        chk("t3_rw_timer", timer_en_o, 1);
        timer_expired_i = 1'b1; step(); timer_expired_i = 1'b0;
        chk("t3_a2_state", state_o, 4);
        chk("t3_a2_req",   rxdet_req_o, 1);
        rxdet_done_i = 1'b1; rxdet_present_i = 4'b0011; step(); rxdet_done_i = 1'b0;
        chk("t3_done_state", state_o, 5);
        chk("t3_done_lanes", lanes_active_o, 4'b0011);

        // Partial detection, retry disagrees
        ltssm_en_i = 1'b0; step();
        ltssm_en_i = 1'b1; step();
        timer_expired_i = 1'b1; step(); timer_expired_i = 1'b0;
        rxdet_done_i = 1'b1; rxdet_present_i = 4'b0011; step(); rxdet_done_i = 1'b0;
        timer_expired_i = 1'b1; step(); timer_expired_i = 1'b0;
        rxdet_done_i = 1'b1; rxdet_present_i = 4'b0001; step(); rxdet_done_i = 1'b0;
        chk("t3_fail_state", state_o, 1);
        chk("t3_fail_done",  detect_done_o, 0);

        // No receivers; expiry ignored in ACTIVE1
        timer_expired_i = 1'b1; step();
        chk("t4_a1_state", state_o, 2);
        chk("t4_a1_timer", timer_en_o, 0);
        step(); timer_expired_i = 1'b0;
        chk("t4_ignexp_state", state_o, 2);
        rxdet_done_i = 1'b1; rxdet_present_i = 4'h0; step(); rxdet_done_i = 1'b0;
        chk("t4_none_state", state_o, 1);
        chk("t4_none_timer", timer_en_o, 1);

        // Watchdog expiry after 64 cycles without done
        timer_expired_i = 1'b1; step(); timer_expired_i = 1'b0;
        for (int i = 0; i < 63; i++) step();
        chk("t5_wd_hold", state_o, 2);
        step();
        chk("t5_wd_quiet", state_o, 1);

        // Done on the 64th cycle wins over the watchdog
        timer_expired_i = 1'b1; step(); timer_expired_i = 1'b0;
        for (int i = 0; i < 63; i++) step();
        rxdet_done_i = 1'b1; rxdet_present_i = 4'hF; step(); rxdet_done_i = 1'b0;
        chk("t5_race_state", state_o, 5);
        chk("t5_race_lanes", lanes_active_o, 4'hF);
        timer_expired_i = 1'b1; step(); timer_expired_i = 1'b0;
        chk("t4_done_ignexp", state_o, 5);
        ltssm_en_i = 1'b0; step();

        // Electrical-idle exit and interruptions
        ltssm_en_i = 1'b1; step();
        eidle_exit_i = 4'b0100; step(); eidle_exit_i = '0;
        chk("t6_eidle_state", state_o, 2);
        rxdet_done_i = 1'b1; rxdet_present_i = 4'b0011; step(); rxdet_done_i = 1'b0;
        chk("t6_rw_state", state_o, 3);
        ltssm_en_i = 1'b0; step();
        chk("t6_drop_state", state_o, 0);
        chk("t6_drop_timer", timer_en_o, 0);
        ltssm_en_i = 1'b1; step();
        timer_expired_i = 1'b1; step(); timer_expired_i = 1'b0;
        rxdet_done_i = 1'b1; rxdet_present_i = 4'b0011; step(); rxdet_done_i = 1'b0;
        timer_expired_i = 1'b1; step(); timer_expired_i = 1'b0;
        chk("t6_a2_req", rxdet_req_o, 1);
        #2 rst_ni = 1'b0;
        #1;
        chk("t6_arst_state", state_o, 0);
        chk("t6_arst_req",   rxdet_req_o, 0);
        chk("t6_arst_timer", timer_en_o, 0);
        chk("t6_arst_done",  detect_done_o, 0);
        chk("t6_arst_lanes", lanes_active_o, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
